// File: rtl/ctrl_ramdrv_coefgen_pkg.sv
// Shared controller package for the coefficient address generator: FSM encoding,
// channel-select width derivation and config register reset value.
package ctrl_ramdrv_coefgen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int CFG_RST_VAL = 0;

    // A single channel still needs a one-bit select so port widths never collapse to zero.
    function automatic int ch_width_f(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

endpackage

// File: rtl/ctrl_ramdrv_coefgen_if.sv
// Sequencer/CPU-facing bundle of the coefficient address generator.
// master = sequencer/config side, slave = ctrl_ramdrv_coefgen.
interface ctrl_ramdrv_coefgen_if
    import ctrl_ramdrv_coefgen_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CH_NUM     = 4,
    parameter int LEN_WIDTH  = 8
);
    localparam int CH_WIDTH = ch_width_f(CH_NUM);

    logic                  cfg_we;
    logic [CH_WIDTH-1:0]   cfg_ch;
    logic [ADDR_WIDTH-1:0] cfg_base;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic                  start;
    logic [CH_WIDTH-1:0]   ch_sel;
    logic                  en;
    logic [ADDR_WIDTH-1:0] coef_addr;
    logic                  coef_vld;
    logic                  coef_last;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cfg_we, cfg_ch, cfg_base, cfg_len, start, ch_sel, en,
        input  coef_addr, coef_vld, coef_last, busy, done, err
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_base, cfg_len, start, ch_sel, en,
        output coef_addr, coef_vld, coef_last, busy, done, err
    );

endinterface

// File: rtl/ctrl_ramdrv_coefcfg.sv
// Per-channel base/len register file with one write port and a channel-select read mux.
// Out-of-range channels are never written and read back as zero (a len=0 window).
module ctrl_ramdrv_coefcfg
    import ctrl_ramdrv_coefgen_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 8,
    parameter int CH_NUM     = 4,
    parameter int CH_WIDTH   = ch_width_f(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  we,
    input  logic [CH_WIDTH-1:0]   wr_ch,
    input  logic [ADDR_WIDTH-1:0] wr_base,
    input  logic [LEN_WIDTH-1:0]  wr_len,
    input  logic [CH_WIDTH-1:0]   rd_ch,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic [LEN_WIDTH-1:0]  rd_len
);

    logic [ADDR_WIDTH-1:0] base_q [CH_NUM];
    logic [LEN_WIDTH-1:0]  len_q  [CH_NUM];

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < CH_NUM; i++) begin
                base_q[i] <= ADDR_WIDTH'(CFG_RST_VAL);
                len_q[i]  <= LEN_WIDTH'(CFG_RST_VAL);
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (we && (wr_ch == CH_WIDTH'(i))) begin
                    base_q[i] <= wr_base;
                    len_q[i]  <= wr_len;
                end
            end
        end
    end

    always_comb begin
        rd_base = '0;
        rd_len  = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (rd_ch == CH_WIDTH'(i)) begin
                rd_base = base_q[i];
                rd_len  = len_q[i];
            end
        end
    end

endmodule

// File: rtl/ctrl_ramdrv_coefgen.sv
// Multi-channel coefficient address generator: walks a channel's base/len window one
// address per enabled cycle. Optional sticky error detection under `COEFGEN_ERR_EN.
module ctrl_ramdrv_coefgen
    import ctrl_ramdrv_coefgen_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int CH_NUM     = 4,
    parameter int LEN_WIDTH  = 8
) (
    input logic                 clk,
    input logic                 clr,
    ctrl_ramdrv_coefgen_if.slave bus
);

    localparam int CH_WIDTH = ch_width_f(CH_NUM);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_t                state;
    logic [LEN_WIDTH-1:0]  idx;
    logic [LEN_WIDTH-1:0]  last_idx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  vld_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] sel_base;
    logic [LEN_WIDTH-1:0]  sel_len;

    ctrl_ramdrv_coefcfg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH),
        .CH_NUM     (CH_NUM),
        .CH_WIDTH   (CH_WIDTH)
    ) u_cfg (
        .clk     (clk),
        .clr     (clr),
        .we      (bus.cfg_we),
        .wr_ch   (bus.cfg_ch),
        .wr_base (bus.cfg_base),
        .wr_len  (bus.cfg_len),
        .rd_ch   (bus.ch_sel),
        .rd_base (sel_base),
        .rd_len  (sel_len)
    );

    // Working copies of base/len are taken at start, so config writes never disturb a live walk.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            state    <= ST_IDLE;
            idx      <= '0;
            last_idx <= '0;
            addr_q   <= '0;
            vld_q    <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (sel_len != '0) begin
                            state    <= ST_RUN;
                            addr_q   <= sel_base;
                            idx      <= '0;
                            last_idx <= sel_len - LEN_ONE;
                            vld_q    <= 1'b1;
                            busy_q   <= 1'b1;
                            last_q   <= (sel_len == LEN_ONE);
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.en) begin
                        if (idx == last_idx) begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                            vld_q  <= 1'b0;
                            busy_q <= 1'b0;
                            last_q <= 1'b0;
                        end else begin
                            idx    <= idx + LEN_ONE;
                            addr_q <= addr_q + ADDR_ONE;
                            last_q <= ((idx + LEN_ONE) == last_idx);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.coef_addr = addr_q;
    assign bus.coef_vld  = vld_q;
    assign bus.coef_last = last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

`ifdef COEFGEN_ERR_EN
    localparam int SPAN_W = ADDR_WIDTH + LEN_WIDTH + 1;

    logic              err_q;
    logic [SPAN_W-1:0] span_end;
    logic              start_wrap;
    logic              start_in_run;
    logic              cfg_bad;
    logic              sel_bad;

    // Last tap address computed wide enough that any carry out of ADDR_WIDTH is visible.
    assign span_end     = SPAN_W'(sel_base) + SPAN_W'(sel_len) - SPAN_W'(1);
    assign start_wrap   = bus.start && (state != ST_RUN) && (sel_len != '0) &&
                          (span_end[SPAN_W-1:ADDR_WIDTH] != '0);
    assign start_in_run = bus.start && (state == ST_RUN);
    assign cfg_bad      = bus.cfg_we && (int'(bus.cfg_ch) >= CH_NUM);
    assign sel_bad      = bus.start && (int'(bus.ch_sel) >= CH_NUM);

    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            err_q <= 1'b0;
        end else if (start_wrap || start_in_run || cfg_bad || sel_bad) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_ramdrv_coefgen.sv
// Self-checking bench for ctrl_ramdrv_coefgen: directed table, corner sequences and
// randomized traffic against a queue-based reference model of the window walk.
module tb_ctrl_ramdrv_coefgen;

    localparam int AW = 12;
    localparam int NCH = 4;
    localparam int LW = 8;
`ifdef COEFGEN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;

    ctrl_ramdrv_coefgen_if #(.ADDR_WIDTH(AW), .CH_NUM(NCH), .LEN_WIDTH(LW)) bus ();

    ctrl_ramdrv_coefgen #(.ADDR_WIDTH(AW), .CH_NUM(NCH), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the remaining window is a queue of addresses still to be presented.
    int unsigned     q[$];
    logic [AW-1:0]   m_addr;
    bit              m_done;
    bit              m_err;
    logic [AW-1:0]   m_base [NCH];
    logic [LW-1:0]   m_len  [NCH];

    typedef struct {
        bit          we;
        bit [1:0]    wch;
        bit [AW-1:0] wbase;
        bit [LW-1:0] wlen;
        bit          st;
        bit [1:0]    sel;
        bit          en;
        bit [AW-1:0] e_addr;
        bit          e_vld;
        bit          e_last;
        bit          e_busy;
        bit          e_done;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_addr = '0;
        m_done = 0;
        m_err  = 0;
        for (int i = 0; i < NCH; i++) begin
            m_base[i] = '0;
            m_len[i]  = '0;
        end
    endtask

    task automatic model_edge(input bit we, input bit [1:0] wch, input bit [AW-1:0] wb,
                              input bit [LW-1:0] wl, input bit st, input bit [1:0] sel,
                              input bit en);
        bit nd = 0;
        int L;
        if (q.size() != 0) begin
            if (st) m_err = 1;
            if (en) begin
                void'(q.pop_front());
                if (q.size() == 0) nd = 1;
                else m_addr = AW'(q[0]);
            end
        end else if (st) begin
            L = (int'(sel) < NCH) ? int'(m_len[sel]) : 0;
            if (L == 0) begin
                nd = 1;
            end else begin
                for (int k = 0; k < L; k++)
                    q.push_back((int'(m_base[sel]) + k) % (1 << AW));
                m_addr = m_base[sel];
                if (int'(m_base[sel]) + L - 1 > (1 << AW) - 1) m_err = 1;
            end
        end
        if (we) begin
            if (int'(wch) < NCH) begin
                m_base[wch] = wb;
                m_len[wch]  = wl;
            end else begin
                m_err = 1;
            end
        end
        m_done = nd;
    endtask

    task automatic compare_model();
        check("addr", 32'(bus.coef_addr), 32'(m_addr));
        check("vld",  32'(bus.coef_vld),  32'(q.size() != 0));
        check("last", 32'(bus.coef_last), 32'(q.size() == 1));
        check("busy", 32'(bus.busy),      32'(q.size() != 0));
        check("done", 32'(bus.done),      32'(m_done));
        check("err",  32'(bus.err),       32'(ERR_EN & m_err));
    endtask

    task automatic step(input bit we, input bit [1:0] wch, input bit [AW-1:0] wb,
                        input bit [LW-1:0] wl, input bit st, input bit [1:0] sel,
                        input bit en);
        bus.cfg_we   = we;
        bus.cfg_ch   = wch;
        bus.cfg_base = wb;
        bus.cfg_len  = wl;
        bus.start    = st;
        bus.ch_sel   = sel;
        bus.en       = en;
        @(negedge clk);
        model_edge(we, wch, wb, wl, st, sel, en);
        #1;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_addr"}, 32'(bus.coef_addr), 32'h0);
        check({tag, "_vld"},  32'(bus.coef_vld),  32'h0);
        check({tag, "_last"}, 32'(bus.coef_last), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy),      32'h0);
        check({tag, "_done"}, 32'(bus.done),      32'h0);
        check({tag, "_err"},  32'(bus.err),       32'h0);
    endtask

    task automatic idle_inputs();
        bus.cfg_we = 0; bus.cfg_ch = 0; bus.cfg_base = 0; bus.cfg_len = 0;
        bus.start = 0;  bus.ch_sel = 0; bus.en = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        bit [AW-1:0] rb;

        tbl[0] = '{1, 2'd1, 12'h100, 8'd4, 0, 2'd0, 0, 12'h000, 0, 0, 0, 0};
        tbl[1] = '{0, 2'd0, 12'h000, 8'd0, 1, 2'd1, 1, 12'h100, 1, 0, 1, 0};
        tbl[2] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1, 12'h101, 1, 0, 1, 0};
        tbl[3] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 0, 12'h101, 1, 0, 1, 0};
        tbl[4] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 0, 12'h101, 1, 0, 1, 0};
        tbl[5] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1, 12'h102, 1, 0, 1, 0};
        tbl[6] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1, 12'h103, 1, 1, 1, 0};
        tbl[7] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1, 12'h103, 0, 0, 0, 1};
        tbl[8] = '{0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1, 12'h103, 0, 0, 0, 0};

        idle_inputs();
        clr = 1'b1;
        model_reset();
        #7;
        check_all_zero("reset");
        @(posedge clk);
        clr = 1'b0;

        // Directed walk ch1 base 0x100 len 4 with a two-cycle stall after 0x101.
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].we, tbl[i].wch, tbl[i].wbase, tbl[i].wlen,
                 tbl[i].st, tbl[i].sel, tbl[i].en);
            check($sformatf("tbl%0d_addr", i), 32'(bus.coef_addr), 32'(tbl[i].e_addr));
            check($sformatf("tbl%0d_vld", i),  32'(bus.coef_vld),  32'(tbl[i].e_vld));
            check($sformatf("tbl%0d_last", i), 32'(bus.coef_last), 32'(tbl[i].e_last));
            check($sformatf("tbl%0d_busy", i), 32'(bus.busy),      32'(tbl[i].e_busy));
            check($sformatf("tbl%0d_done", i), 32'(bus.done),      32'(tbl[i].e_done));
        end

        // Len=0 start, then back-to-back start in the DONE cycle.
        step(1, 2'd3, 12'h200, 8'd0, 0, 2'd0, 0);
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd3, 1);
        check("len0_vld",  32'(bus.coef_vld), 32'h0);
        check("len0_done", 32'(bus.done),     32'h1);
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd1, 1);
        check("b2b_vld",  32'(bus.coef_vld),  32'h1);
        check("b2b_addr", 32'(bus.coef_addr), 32'h100);
        for (int i = 0; i < 4; i++) step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
        check("b2b_done", 32'(bus.done), 32'h1);

        // Config write to the live channel must not change the current walk.
        nv = 0;
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd1, 1);
        if (bus.coef_vld) nv++;
        step(1, 2'd1, 12'h100, 8'd8, 0, 2'd0, 1);
        if (bus.coef_vld) nv++;
        for (int i = 0; i < 6; i++) begin
            step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
            if (bus.coef_vld) nv++;
        end
        check("live_cfg_len", 32'(nv), 32'd4);
        nv = 0;
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd1, 1);
        if (bus.coef_vld) nv++;
        for (int i = 0; i < 10; i++) begin
            step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
            if (bus.coef_vld) nv++;
        end
        check("new_cfg_len", 32'(nv), 32'd8);

        // Wrap past all-ones, plus an ignored start while running.
        step(1, 2'd2, 12'hFFE, 8'd4, 0, 2'd0, 0);
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd2, 1);
        step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
        step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
        check("wrap_addr", 32'(bus.coef_addr), 32'h000);
        check("wrap_err",  32'(bus.err),       32'(ERR_EN));
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd1, 1);
        check("wrap_last", 32'(bus.coef_addr), 32'h001);
        for (int i = 0; i < 3; i++) step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);

        // Asynchronous clear in the middle of a walk.
        step(0, 2'd0, 12'h000, 8'd0, 1, 2'd1, 1);
        step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
        idle_inputs();
        #3;
        clr = 1'b1;
        #1;
        check_all_zero("async_clr");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        clr = 1'b0;
        step(0, 2'd0, 12'h000, 8'd0, 0, 2'd0, 1);
        check("post_clr_done", 32'(bus.done), 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rb = AW'($urandom_range(0, (1 << AW) - 1));
            if ($urandom_range(0, 3) == 0) rb = 12'hFF0 | AW'($urandom_range(0, 15));
            step($urandom_range(0, 7) == 0, 2'($urandom_range(0, 3)), rb,
                 LW'($urandom_range(0, 9)), $urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
